// File: rtl/seg_pkg.sv
// Seven-segment code constants, encoder and elaboration helpers shared by the score display.
// Codes are active low, bit n drives segment n (0 top ... 6 middle).
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SHOW = 2'd2
    } state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

    // Evaluated at elaboration only, to size the decimal overflow bound.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one add-3/shift step per clock, BIN_W steps.
// last is high during the final step; valid pulses for one cycle once bcd holds the result.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  last,
    output logic                  valid
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_d[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                  : bcd_q[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(BIN_W);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            bcd_q   <= {bcd_d[4*DIGITS-2:0], bin_q[BIN_W-1]};
            bin_q   <= bin_q << 1;
            cnt_q   <= cnt_q - CNT_W'(1);
            valid_q <= (cnt_q == CNT_W'(1));
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bcd   = bcd_q;
    assign last  = (cnt_q == CNT_W'(1));
    assign valid = valid_q;

endmodule

// File: rtl/score_display.sv
// Multi-digit seven-segment driver: binary value shown as decimal (double-dabble) or hex nibbles.
// Build option SCORE_DISPLAY_LZ_BLANK_EN blanks leading zero digits; digit 0 and dashes are never blanked.
module score_display
    import seg_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      value,
    input  logic                  load,
    input  logic                  hex_mode,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int          HW      = 4 * DIGITS;
    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [7*DIGITS-1:0] seg_q;
    logic                mode_q;
    logic                ovf_q;
    logic [HW-1:0]       hexval_q;

    logic                conv_start;
    logic [HW-1:0]       conv_bcd;
    logic                conv_last;
    logic                conv_valid;
    logic                dec_ovf;
    logic                hex_ovf;
    logic [HW-1:0]       hex_src;
    logic [HW-1:0]       nib_all;
    logic [7*DIGITS-1:0] seg_d;

    assign conv_start = (state_q == IDLE) && load && !hex_mode;
    assign dec_ovf    = 64'(value) > DEC_MAX;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (value),
        .bcd   (conv_bcd),
        .last  (conv_last),
        .valid (conv_valid)
    );

    // Hex needs DIGITS nibbles: bits above them overflow, a narrower input is zero-extended.
    generate
        if (BIN_W > HW) begin : g_hex_wide
            assign hex_ovf = |value[BIN_W-1:HW];
            assign hex_src = value[HW-1:0];
        end else if (BIN_W == HW) begin : g_hex_exact
            assign hex_ovf = 1'b0;
            assign hex_src = value;
        end else begin : g_hex_narrow
            assign hex_ovf = 1'b0;
            assign hex_src = {{(HW - BIN_W){1'b0}}, value};
        end
    endgenerate

    assign nib_all = mode_q ? hexval_q : conv_bcd;

    genvar gi;
    generate
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
        logic [DIGITS-1:0] lz;
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign lz[gi] = 1'b0;
            end else begin : g_upper
                assign lz[gi] = ~|nib_all[HW-1:4*gi];
            end
            assign seg_d[7*gi +: 7] = ovf_q  ? SEG_DASH  :
                                      lz[gi] ? SEG_BLANK :
                                               seg_encode(nib_all[4*gi +: 4]);
        end
`else
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign seg_d[7*gi +: 7] = ovf_q ? SEG_DASH : seg_encode(nib_all[4*gi +: 4]);
        end
`endif
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            seg_q    <= '1;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hexval_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        busy_q   <= 1'b1;
                        mode_q   <= hex_mode;
                        ovf_q    <= hex_mode ? hex_ovf : dec_ovf;
                        hexval_q <= hex_src;
                        state_q  <= hex_mode ? SHOW : CONV;
                    end
                end
                CONV: begin
                    if (conv_last) begin
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
                    // The converter's valid pulse coincides with SHOW on the decimal path.
                    if (mode_q || conv_valid) begin
                        seg_q   <= seg_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display (DIGITS=6, BIN_W=20) with hand-computed segment patterns.
module tb_score_display;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] DA = 7'b0001000;
    localparam logic [6:0] DB = 7'b0000011;
    localparam logic [6:0] DC = 7'b1000110;
    localparam logic [6:0] DD = 7'b0100001;
    localparam logic [6:0] DE = 7'b0000110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = D0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] value;
    logic        load;
    logic        hex_mode;
    logic        busy;
    logic        done;
    logic [41:0] seg;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int bcy;
    int dones;
    int first_done;
    int second_done;

    always #5 clk = ~clk;

    score_display #(
        .DIGITS (6),
        .BIN_W  (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .hex_mode (hex_mode),
        .busy     (busy),
        .done     (done),
        .seg      (seg)
    );

    function automatic logic [41:0] seg6(input logic [6:0] c5, c4, c3, c2, c1, c0);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then count edges (after E0) until done, with a bounded wait.
    task automatic run_req(input logic [19:0] v, input logic h, output int lat_o, output int bcy_o);
        @(negedge clk);
        value    = v;
        hex_mode = h;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        lat_o = -1;
        bcy_o = 0;
        for (int k = 1; k <= 60; k++) begin
            if (busy) bcy_o++;
            @(posedge clk);
            #1;
            if (done) begin
                lat_o = k;
                break;
            end
        end
        $display("req value=%0d hex=%0b latency=%0d busy_cycles=%0d seg=%h", v, h, lat_o, bcy_o, seg);
    endtask

    task automatic after_done(input string tag);
        chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        hex_mode = 1'b0;
        value    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_seg", 64'(seg), 64'({42{1'b1}}));
        @(negedge clk);
        rst = 1'b0;

        run_req(20'd0, 1'b0, lat, bcy);
        chk("dec0_latency", 64'(lat), 64'd21);
        chk("dec0_seg", 64'(seg), 64'(seg6(LZ, LZ, LZ, LZ, LZ, D0)));
        after_done("dec0");

        run_req(20'd123456, 1'b0, lat, bcy);
        chk("dec123456_latency", 64'(lat), 64'd21);
        chk("dec123456_busy_cycles", 64'(bcy), 64'd21);
        chk("dec123456_seg", 64'(seg), 64'(seg6(D1, D2, D3, D4, D5, D6)));
        after_done("dec123456");

        run_req(20'd999999, 1'b0, lat, bcy);
        chk("dec999999_seg", 64'(seg), 64'(seg6(D9, D9, D9, D9, D9, D9)));
        after_done("dec999999");

        run_req(20'd1000000, 1'b0, lat, bcy);
        chk("dec_ovf_latency", 64'(lat), 64'd21);
        chk("dec_ovf_seg", 64'(seg), 64'(seg6(DS, DS, DS, DS, DS, DS)));
        after_done("dec_ovf");

        run_req(20'hABCDE, 1'b1, lat, bcy);
        chk("hex_latency", 64'(lat), 64'd1);
        chk("hex_busy_cycles", 64'(bcy), 64'd1);
        chk("hex_seg", 64'(seg), 64'(seg6(LZ, DA, DB, DC, DD, DE)));
        after_done("hex");

        run_req(20'd7, 1'b0, lat, bcy);
        chk("dec7_seg", 64'(seg), 64'(seg6(LZ, LZ, LZ, LZ, LZ, D7)));
        after_done("dec7");

        // A second load five edges into a conversion must be dropped.
        @(negedge clk);
        value    = 20'd42;
        hex_mode = 1'b0;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        value = 20'd7;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        lat  = -1;
        for (int k = 6; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        $display("req value=42 with ignored load of 7 latency=%0d seg=%h", lat, seg);
        chk("busy_ignore_latency", 64'(lat), 64'd21);
        chk("busy_ignore_seg", 64'(seg), 64'(seg6(LZ, LZ, LZ, LZ, D4, D2)));
        after_done("busy_ignore");
        chk("busy_ignore_no_queue", 64'(busy), 64'd0);

        // Reset at edge E10 aborts the conversion.
        @(negedge clk);
        value = 20'd555555;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_seg", 64'(seg), 64'({42{1'b1}}));
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        $display("req value=555555 aborted by reset, later done pulses=%0d", dones);
        chk("abort_no_done", 64'(dones), 64'd0);

        run_req(20'd5, 1'b0, lat, bcy);
        chk("post_abort_latency", 64'(lat), 64'd21);
        chk("post_abort_seg", 64'(seg), 64'(seg6(LZ, LZ, LZ, LZ, LZ, D5)));
        after_done("post_abort");

        // load held high: the second request starts on the IDLE edge right after done.
        @(negedge clk);
        value       = 20'd3;
        hex_mode    = 1'b0;
        load        = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int k = 0; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_done < 0) begin
                    first_done = k;
                end else begin
                    second_done = k;
                    load = 1'b0;
                    break;
                end
            end
        end
        load = 1'b0;
        $display("req value=3 held load, done at E%0d and E%0d", first_done, second_done);
        chk("b2b_first_done", 64'(first_done), 64'd21);
        chk("b2b_second_done", 64'(second_done), 64'd43);
        chk("b2b_seg", 64'(seg), 64'(seg6(LZ, LZ, LZ, LZ, LZ, D3)));
        @(posedge clk);
        #1;
        chk("b2b_idle_after_release", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
